// File: rtl/clacc_pe_pkg.sv
// Shared PE-level definitions: spad geometry, word width and the
// ifmap spad loader state encoding, plus config normalisation helpers.
package clacc_pe_pkg;

    localparam int DATA_W      = 16;
    localparam int SPAD_DEPTH  = 16;
    localparam int SPAD_ADDR_W = 4;
    localparam int REUSE_W     = 4;

    localparam logic [SPAD_ADDR_W:0] FULL_LEN  = (SPAD_ADDR_W+1)'(SPAD_DEPTH);
    localparam logic [REUSE_W-1:0]   ONE_REUSE = REUSE_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } loader_state_t;

    // A zero or oversized length means "fill the whole spad".
    function automatic logic [SPAD_ADDR_W:0] norm_fill_len(input logic [SPAD_ADDR_W:0] len);
        if (len == '0 || len > FULL_LEN) begin
            return FULL_LEN;
        end
        return len;
    endfunction

    // Zero replay passes would never emit anything, so treat it as one pass.
    function automatic logic [REUSE_W-1:0] norm_reuse(input logic [REUSE_W-1:0] reuse);
        return (reuse == '0) ? ONE_REUSE : reuse;
    endfunction

endpackage

// File: rtl/ifmap_spad_loader_if.sv
// Word streams around the ifmap spad loader: the GLB-side fill stream
// and the MAC-side replay stream. The loader takes the slave side.
interface ifmap_spad_loader_if;
    import clacc_pe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ifmap_spad.sv
// 16x16 ifmap scratchpad: synchronous write, combinational read.
// The shared data port is driven by the spad only while not writing.
module ifmap_spad
    import clacc_pe_pkg::*;
(
    input  logic                   clk,
    input  logic [SPAD_ADDR_W-1:0] addr,
    input  logic                   we,
    inout  wire  [DATA_W-1:0]      data_port
);

    logic [DATA_W-1:0] mem [SPAD_DEPTH];

    // Capture the word on the shared port when the loader writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data_port;
        end
    end

    assign data_port = we ? {DATA_W{1'bz}} : mem[addr];

endmodule

// File: rtl/ifmap_spad_loader.sv
// Ifmap spad loader: fills the spad from the GLB stream, then replays the
// stored segment to the MAC a configurable number of times.
module ifmap_spad_loader
    import clacc_pe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SPAD_ADDR_W:0]   fill_len,
    input  logic [REUSE_W-1:0]     reuse_cnt,
    ifmap_spad_loader_if.slave     bus,
    output logic [SPAD_ADDR_W-1:0] spad_addr,
    output logic                   spad_we,
    inout  wire  [DATA_W-1:0]      spad_data,
    output logic                   busy,
    output logic                   done
);

    loader_state_t state, next_state;

    logic [SPAD_ADDR_W:0]   len;
    logic [REUSE_W-1:0]     reuse;
    logic [SPAD_ADDR_W-1:0] wr_ptr;
    logic [SPAD_ADDR_W-1:0] rd_ptr;
    logic [REUSE_W-1:0]     pass;
    logic                   issued_all;
    logic                   out_valid_q;
    logic [DATA_W-1:0]      out_data_q;
    logic                   out_last_q;
    logic                   in_ready_c;

    logic [SPAD_ADDR_W:0] len_m1;
    logic [REUSE_W-1:0]   reuse_m1;
    logic                 wr_last;
    logic                 rd_last;
    logic                 load;
    logic                 final_accept;

    assign len_m1       = len - {{SPAD_ADDR_W{1'b0}}, 1'b1};
    assign reuse_m1     = reuse - ONE_REUSE;
    assign wr_last      = ({1'b0, wr_ptr} == len_m1);
    assign rd_last      = ({1'b0, rd_ptr} == len_m1);
    assign load         = (state == DRAIN) && (!out_valid_q || bus.out_ready) && !issued_all;
    assign final_accept = out_valid_q && bus.out_ready && issued_all;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the per-state control outputs.
    always_comb begin
        next_state = state;
        in_ready_c = 1'b0;
        spad_we    = 1'b0;
        spad_addr  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                in_ready_c = 1'b1;
                spad_we    = bus.in_valid;
                spad_addr  = wr_ptr;
                busy       = 1'b1;
                if (bus.in_valid && wr_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                spad_addr = rd_ptr;
                busy      = 1'b1;
                if (final_accept) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Config capture, pointers and the MAC-side output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= '0;
            reuse       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pass        <= '0;
            issued_all  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len    <= norm_fill_len(fill_len);
                        reuse  <= norm_reuse(reuse_cnt);
                        wr_ptr <= '0;
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
                        wr_ptr <= wr_ptr + SPAD_ADDR_W'(1);
                        if (wr_last) begin
                            rd_ptr     <= '0;
                            pass       <= '0;
                            issued_all <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (load) begin
                        out_data_q  <= spad_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= rd_last;
                        if (rd_last) begin
                            rd_ptr <= '0;
                            pass   <= pass + ONE_REUSE;
                            if (pass == reuse_m1) begin
                                issued_all <= 1'b1;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + SPAD_ADDR_W'(1);
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    assign spad_data = spad_we ? bus.in_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ifmap_spad_loader.sv
// Bench for the ifmap spad loader together with the ifmap spad on a
// shared data net. A stream-level model predicts writes and the replayed
// word sequence; directed jobs add literal expectations.
module tb_ifmap_spad_loader;
    import clacc_pe_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [SPAD_ADDR_W:0]   fill_len = '0;
    logic [REUSE_W-1:0]     reuse_cnt = '0;
    logic [SPAD_ADDR_W-1:0] spad_addr;
    logic                   spad_we;
    logic                   busy;
    logic                   done;
    wire  [DATA_W-1:0]      spad_data;

    ifmap_spad_loader_if bus();

    ifmap_spad_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fill_len  (fill_len),
        .reuse_cnt (reuse_cnt),
        .bus       (bus),
        .spad_addr (spad_addr),
        .spad_we   (spad_we),
        .spad_data (spad_data),
        .busy      (busy),
        .done      (done)
    );

    ifmap_spad spad (
        .clk       (clk),
        .addr      (spad_addr),
        .we        (spad_we),
        .data_port (spad_data)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks_total++;
        if (actual === required) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Model state
    logic [DATA_W-1:0] model_mem [SPAD_DEPTH];
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W:0]   front;
    bit                model_busy, fill_active, done_expect, prev_stall, exp_we;
    int                model_len, model_reuse, write_idx;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    int                accepted_count, last_count, write_count, done_count;
    logic [DATA_W-1:0] first_word, last_word;

    // Compare process: checks DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_busy  = 1'b0;
            fill_active = 1'b0;
            done_expect = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (bus.in_ready || fill_active) checkOutput("in_ready", 32'(bus.in_ready), 32'(fill_active));
            exp_we = fill_active && bus.in_valid;
            if (spad_we || exp_we) checkOutput("spad_we", 32'(spad_we), 32'(exp_we));
            if (exp_we) begin
                checkOutput("wr_addr", 32'(spad_addr), 32'(write_idx));
                checkOutput("wr_data", 32'(spad_data), 32'(bus.in_data));
                model_mem[write_idx] = bus.in_data;
                write_idx++;
                write_count++;
                if (write_idx == model_len) begin
                    fill_active = 1'b0;
                    for (int p = 0; p < model_reuse; p++) begin
                        for (int k = 0; k < model_len; k++) begin
                            exp_q.push_back({(k == model_len - 1), model_mem[k]});
                        end
                    end
                end
            end
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("stall_data", 32'(bus.out_data), 32'(prev_data));
                checkOutput("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (done || done_expect) checkOutput("done", 32'(done), 32'(done_expect));
            if (done) done_count++;
            done_expect = 1'b0;
            checkOutput("busy", 32'(busy), 32'(model_busy));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("word_count", 32'(accepted_count + 1), 32'(model_len * model_reuse));
                end else begin
                    front = exp_q.pop_front();
                    checkOutput("out_data", 32'(bus.out_data), 32'(front[DATA_W-1:0]));
                    checkOutput("out_last", 32'(bus.out_last), 32'(front[DATA_W]));
                    if (exp_q.size() == 0) begin
                        done_expect = 1'b1;
                        model_busy  = 1'b0;
                    end
                end
                accepted_count++;
                if (accepted_count == 1) first_word = bus.out_data;
                last_word = bus.out_data;
                if (bus.out_last) last_count++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (start && !model_busy) begin
                model_len      = (fill_len == 0 || fill_len > SPAD_DEPTH) ? SPAD_DEPTH : int'(fill_len);
                model_reuse    = (reuse_cnt == 0) ? 1 : int'(reuse_cnt);
                fill_active    = 1'b1;
                write_idx      = 0;
                model_busy     = 1'b1;
                accepted_count = 0;
                last_count     = 0;
                write_count    = 0;
                done_count     = 0;
            end
        end
    end

    logic [DATA_W-1:0] stim_words [SPAD_DEPTH];

    // Pulse start with a config, then stream n words (optional idle gaps,
    // optional second start pulse at word inject_idx).
    task automatic applyStimulus(input int len, input int reuse, input int n, input bit gap, input int inject_idx);
        @(posedge clk); #1;
        start     = 1'b1;
        fill_len  = (SPAD_ADDR_W+1)'(len);
        reuse_cnt = REUSE_W'(reuse);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_words[i];
            if (i == inject_idx) begin
                start    = 1'b1;
                fill_len = (SPAD_ADDR_W+1)'(2);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (gap && i < n - 1) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (done_count >= 1) break;
        end
        checkOutput({name, "_done_seen"}, 32'(done_count), 32'd1);
    endtask

    task automatic waitAccepted(input int n);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (accepted_count >= n) break;
        end
        checkOutput("accepted_reached", 32'(accepted_count), 32'(n));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_spad_we", 32'(spad_we), 32'd0);
        checkOutput("rst_spad_addr", 32'(spad_addr), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Job 1: full spad, single pass
        for (int i = 0; i < 16; i++) stim_words[i] = DATA_W'(16'h1000 + i);
        applyStimulus(16, 1, 16, 1'b0, -1);
        waitDone("j1");
        checkOutput("j1_writes", 32'(write_count), 32'd16);
        checkOutput("j1_words", 32'(accepted_count), 32'd16);
        checkOutput("j1_lasts", 32'(last_count), 32'd1);
        checkOutput("j1_first", 32'(first_word), 32'h1000);
        checkOutput("j1_final", 32'(last_word), 32'h100F);

        // Job 2: three words replayed four times
        stim_words[0] = 16'hAAAA;
        stim_words[1] = 16'hBBBB;
        stim_words[2] = 16'hCCCC;
        applyStimulus(3, 4, 3, 1'b0, -1);
        waitDone("j2");
        checkOutput("j2_words", 32'(accepted_count), 32'd12);
        checkOutput("j2_lasts", 32'(last_count), 32'd4);
        checkOutput("j2_first", 32'(first_word), 32'hAAAA);
        checkOutput("j2_final", 32'(last_word), 32'hCCCC);

        // Job 3: gapped fill and a 3-cycle MAC stall mid-drain
        for (int i = 0; i < 5; i++) stim_words[i] = DATA_W'(16'h3100 + 3 * i);
        applyStimulus(5, 2, 5, 1'b1, -1);
        waitAccepted(3);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        waitDone("j3");
        checkOutput("j3_words", 32'(accepted_count), 32'd10);
        checkOutput("j3_lasts", 32'(last_count), 32'd2);
        checkOutput("j3_final", 32'(last_word), 32'h310C);

        // Job 4: zero config normalised, ignored restart, reset mid-drain
        for (int i = 0; i < 16; i++) stim_words[i] = DATA_W'(16'h4000 + i);
        applyStimulus(0, 0, 16, 1'b0, 4);
        checkOutput("j4_writes", 32'(write_count), 32'd16);
        waitAccepted(5);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hDEAD;
        #1;
        checkOutput("j4_words_before_rst", 32'(accepted_count), 32'd5);
        checkOutput("j4_fifth_word", 32'(last_word), 32'h4004);
        checkOutput("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst2_busy", 32'(busy), 32'd0);
        checkOutput("rst2_spad_we", 32'(spad_we), 32'd0);
        checkOutput("rst2_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst2_spad_addr", 32'(spad_addr), 32'd0);
        checkOutput("rst2_spad_net", 32'(spad_data), 32'h4000);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Job 5: short job after reset
        stim_words[0] = 16'h5001;
        stim_words[1] = 16'h5002;
        applyStimulus(2, 1, 2, 1'b0, -1);
        waitDone("j5");
        checkOutput("j5_words", 32'(accepted_count), 32'd2);
        checkOutput("j5_lasts", 32'(last_count), 32'd1);
        checkOutput("j5_final", 32'(last_word), 32'h5002);

        repeat (3) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ifmap_spad_loader.md
Name: ifmap_spad_loader

Overview:
- Sequencer directly upstream/around the 16x16 ifmap_spad inside a PE.
- Accepts an ifmap row segment as a valid/ready word stream from the GLB side and writes it into the spad.
- Then replays the stored segment to the PE MAC datapath as a valid/ready stream, a programmable number of times, for convolutional reuse.
- Owns the spad's addr, we and bidirectional data_port. It drives data_port only while writing.

Parameters:
- DATA_W, 16, word width; matches spad data_port.
- DEPTH, 16, spad entries.
- ADDR_W, 4, log2(DEPTH).
- REUSE_W, 4, width of replay-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches cfg and begins fill; ignored unless IDLE.
- fill_len  in  ADDR_W+1  words to load, 1..DEPTH; sampled on start.
- reuse_cnt  in  REUSE_W  replay passes; sampled on start.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  loader accepts word.
- spad_addr  out  ADDR_W  spad address.
- spad_we  out  1  spad write enable; 1 = write at posedge.
- spad_data  inout  DATA_W  spad data_port; driven by loader iff spad_we=1, else 'z.
- out_valid  out  1  word to MAC valid.
- out_data  out  DATA_W  word to MAC.
- out_last  out  1  marks final word of each pass; qualified by out_valid.
- out_ready  in  1  MAC accepts word.
- busy  out  1  high in FILL or DRAIN.
- done  out  1  one-cycle pulse after final word of final pass is accepted.

Behaviour:
- Spad contract: write at posedge when we=1; read is combinational from addr when we=0.
- Reset (async, any state): state=IDLE; in_ready=0, spad_we=0, spad_addr=0, spad_data hi-Z, out_valid=0, out_data=0, out_last=0, busy=0, done=0; all pointers and counters 0. Spad contents are not cleared.
- Config normalisation at start: fill_len=0 or >DEPTH becomes DEPTH; reuse_cnt=0 becomes 1.
- FSM:
  - IDLE: on start, go to FILL with wr_ptr=0.
  - FILL:
    - in_ready=1, spad_addr=wr_ptr, spad_we=in_valid, spad_data=in_data when in_valid.
    - A transfer (in_valid&in_ready) writes at that posedge and increments wr_ptr.
    - On the transfer with wr_ptr==len-1, go to DRAIN; rd_ptr=0, pass=0.
    - in_ready=0 outside FILL.
  - DRAIN:
    - spad_we=0, spad_addr=rd_ptr.
    - Output register load condition: (!out_valid || out_ready) and words remain. Load out_data<=spad_data, out_valid<=1, out_last<=(rd_ptr==len-1).
    - Pointer update on load: rd_ptr++. At rd_ptr==len-1, rd_ptr wraps to 0 and pass++.
    - First out_valid rises 1 cycle after entering DRAIN.
    - Back-pressure: with out_ready=0 and out_valid=1, out_data, out_last and rd_ptr hold. Sustained throughput is 1 word/cycle with out_ready=1.
    - When out_ready accepts a word and no words remain, out_valid<=0. Completion: the acceptance of the last word of pass reuse-1 moves to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy=0 in DONE and IDLE.
- start while busy: ignored, no cfg change.
- No simultaneous write/read: FILL and DRAIN are exclusive, so the bus is never contended.
- Counters: rd/wr_ptr are ADDR_W wide; fill counting compares against len-1 (ADDR_W+1 compare). pass is REUSE_W wide.

Decomposition:
- Shared package clacc_pe_pkg: DATA_W, SPAD_DEPTH, SPAD_ADDR_W, loader state enum {IDLE, FILL, DRAIN, DONE}.
- No sub-module required. The output register plus load logic may be a small internal always block. The tristate driver stays in this module's top level.
- Bench instantiates ifmap_spad and this block together on the shared spad_data net.

Test Plan:
- Reset then start, fill_len=16, reuse_cnt=1, in_valid held high with words 0x1000..0x100F: 16 write cycles at addr 0..15, spad_data hi-Z afterwards. Output 0x1000..0x100F in order with out_ready=1, out_last only on 0x100F, done one cycle after that acceptance.
- fill_len=3, reuse_cnt=4, data A,B,C: output stream A B C ×4, out_last on every C, 12 words total, then done.
- in_valid toggled 1-0-1 during fill, and out_ready low for 3 cycles mid-drain: no duplicate or dropped words; out_data stable while stalled.
- fill_len=0, reuse_cnt=0: treated as 16 words, 1 pass. A second start pulse mid-FILL is ignored (fill_len unchanged, no restart).
- rst_n asserted mid-DRAIN (after 5 of 16 words): same cycle out_valid=0, busy=0, spad_we=0, data_port hi-Z. A new start with fill_len=2 completes normally.
